// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one active-low column driven per dwell, frame-level ghost
// rejection and debounce. Auto-repeat is built only when KEYPAD_TYPEMATIC_EN is defined.
module keypad_scanner #(
  parameter int  ROWS         = 4,
  parameter int  COLS         = 4,
  parameter int  SCAN_DIV     = 1000,
  parameter int  DEBOUNCE     = 3,
  parameter int  REPEAT_DELAY = 30,
  parameter int  REPEAT_RATE  = 8,
  localparam int CW           = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] rows,
  output logic [COLS-1:0] cols,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int DB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
  localparam logic [COLS-1:0]  COLS_RST = ~(COLS'(1));

  typedef enum logic       {ST_SCAN, ST_EVAL}         state_e;
  typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_INV} frame_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COLS-1:0]  cols_q, cols_d;
  logic             acc_hit_q, acc_hit_d;
  logic             acc_bad_q, acc_bad_d;
  logic [CW-1:0]    acc_code_q, acc_code_d;
  frame_e           fr_kind_q, fr_kind_d;
  logic [CW-1:0]    fr_code_q, fr_code_d;
  logic             prev_key_q, prev_key_d;
  logic [CW-1:0]    prev_code_q, prev_code_d;
  logic [DB_W-1:0]  stab_q, stab_d;
  logic [CW-1:0]    code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
`endif

  logic             row_any, row_multi;
  logic [ROW_W-1:0] row_sel;
  logic [CW-1:0]    sample_code;
  logic             col_hit, smp_hit, smp_bad;
  logic [CW-1:0]    smp_code;
  logic             is_key, same_frame, same_held;

  // Classify the rows seen on the driven column: none, one, or several low.
  always_comb begin
    row_any   = 1'b0;
    row_multi = 1'b0;
    row_sel   = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!rows[r]) begin
        if (row_any) row_multi = 1'b1;
        row_any = 1'b1;
        row_sel = ROW_W'(r);
      end
    end
  end

  assign sample_code = CW'(row_sel) * CW'(COLS) + CW'(col_q);
  assign col_hit     = row_any & ~row_multi;
  assign smp_hit     = acc_hit_q | col_hit;
  assign smp_bad     = acc_bad_q | row_multi | (col_hit & acc_hit_q);
  assign smp_code    = (col_hit && !acc_hit_q) ? sample_code : acc_code_q;

  always_comb begin
    state_d     = ST_SCAN;
    div_d       = div_q + DIV_W'(1);
    col_d       = col_q;
    cols_d      = cols_q;
    acc_hit_d   = acc_hit_q;
    acc_bad_d   = acc_bad_q;
    acc_code_d  = acc_code_q;
    fr_kind_d   = fr_kind_q;
    fr_code_d   = fr_code_q;
    prev_key_d  = prev_key_q;
    prev_code_d = prev_code_q;
    stab_d      = stab_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    held_d      = held_q;
    is_key      = (fr_kind_q == FR_KEY);
    same_frame  = (is_key == prev_key_q) && (!is_key || (fr_code_q == prev_code_q));
    same_held   = held_q && is_key && (code_q == fr_code_q);
`ifdef KEYPAD_TYPEMATIC_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif

    // End of dwell: fold this column into the frame and move the drive on.
    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (col_q == COL_LAST) begin
        col_d      = '0;
        fr_kind_d  = smp_bad ? FR_INV : (smp_hit ? FR_KEY : FR_NONE);
        fr_code_d  = smp_code;
        acc_hit_d  = 1'b0;
        acc_bad_d  = 1'b0;
        acc_code_d = '0;
        state_d    = ST_EVAL;
      end else begin
        col_d      = col_q + COL_W'(1);
        acc_hit_d  = smp_hit;
        acc_bad_d  = smp_bad;
        acc_code_d = smp_code;
      end
      cols_d = ~(COLS'(1) << col_d);
    end

    // Invalid frames leave debounce history and the repeat timer untouched.
    if (state_q == ST_EVAL && fr_kind_q != FR_INV) begin
      if (!same_frame)           stab_d = DB_W'(1);
      else if (stab_q != DB_MAX) stab_d = stab_q + DB_W'(1);
      prev_key_d  = is_key;
      prev_code_d = fr_code_q;

      if (stab_d == DB_MAX && !same_held) begin
        if (is_key) begin
          code_d  = fr_code_q;
          held_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          held_d  = 1'b0;
        end
      end

`ifdef KEYPAD_TYPEMATIC_EN
      if (stab_d == DB_MAX && same_held) begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
        if (rep_cnt_d == (rep_first_q ? REP_FIRST : REP_NEXT)) begin
          valid_d     = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end
      end else begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      div_q      <= '0;
      col_q      <= '0;
      cols_q     <= COLS_RST;
      acc_hit_q  <= 1'b0;
      acc_bad_q  <= 1'b0;
      fr_kind_q  <= FR_NONE;
      prev_key_q <= 1'b0;
      stab_q     <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      col_q      <= col_d;
      cols_q     <= cols_d;
      acc_hit_q  <= acc_hit_d;
      acc_bad_q  <= acc_bad_d;
      fr_kind_q  <= fr_kind_d;
      prev_key_q <= prev_key_d;
      stab_q     <= stab_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  // Codes are only consulted when their hit/key flag is set, so they skip reset.
  always_ff @(posedge clk) begin
    acc_code_q  <= acc_code_d;
    fr_code_q   <= fr_code_d;
    prev_code_q <= prev_code_d;
  end

  assign cols      = cols_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule
